pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_if.sv | 41 ++++
 rtl/pipe_ctrl.sv | 134 +++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle between the hazard/exception sources and the
// pipeline registers.
//   master : drives the stall/exception requests, observes control outputs
//   slave  : pipe_ctrl side, consumes requests, drives stall/flush/new PC
// Signals:
//   id_stall_req_i  ID branch/jr RAW stall request
//   ex_stall_req_i  EX multi-cycle op busy
//   mem_stall_req_i MEM bus wait
//   excp_i          exception/redirect request from MEM
//   excp_pc_i       redirect target, valid with excp_i
//   stall_o         per-stage hold {WB,MEM,EX,ID,IF,PC}
//   flush_o         clear all pipeline registers
//   new_pc_o        PC load value, valid while flush_o=1
//   stall_timeout_o one-cycle watchdog pulse
//   stall_cnt_o     performance stall counter
interface pipe_ctrl_if;
    localparam int unsigned STAGE_W = 6;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned CNT_W   = 32;

    logic               id_stall_req_i;
    logic               ex_stall_req_i;
    logic               mem_stall_req_i;
    logic               excp_i;
    logic [ADDR_W-1:0]  excp_pc_i;
    logic [STAGE_W-1:0] stall_o;
    logic               flush_o;
    logic [ADDR_W-1:0]  new_pc_o;
    logic               stall_timeout_o;
    logic [CNT_W-1:0]   stall_cnt_o;

    modport master (
        output id_stall_req_i, ex_stall_req_i, mem_stall_req_i, excp_i, excp_pc_i,
        input  stall_o, flush_o, new_pc_o, stall_timeout_o, stall_cnt_o
    );

    modport slave (
        input  id_stall_req_i, ex_stall_req_i, mem_stall_req_i, excp_i, excp_pc_i,
        output stall_o, flush_o, new_pc_o, stall_timeout_o, stall_cnt_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller.
// Resolves stall requests into per-stage holds (mem > ex > id), turns an
// exception into a one-cycle flush with a registered redirect PC, and runs a
// stall watchdog with a saturating one-shot timeout pulse.
// Ports:
//   clk_i   : clock, rising edge
//   rst_n_i : asynchronous active-low reset
//   bus     : pipe_ctrl_if.slave (requests in; stall/flush/new_pc/timeout/count out)
// Build option:
//   PIPE_CTRL_PERF_EN : when defined, stall_cnt_o counts stalled RUN cycles
//                       (saturating, not cleared by flush); otherwise it is tied 0.
module pipe_ctrl (
    input  logic        clk_i,
    input  logic        rst_n_i,
    pipe_ctrl_if.slave  bus
);
    localparam int unsigned STAGE_W = 6;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned WDOG_W  = 8;
    localparam int unsigned CNT_W   = 32;

    localparam logic [STAGE_W-1:0] STALL_MEM  = 6'b011111;
    localparam logic [STAGE_W-1:0] STALL_EX   = 6'b001111;
    localparam logic [STAGE_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STAGE_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [WDOG_W-1:0]  WDOG_MAX   = '1;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic                flush_q, flush_d;
    logic [ADDR_W-1:0]   new_pc_q, new_pc_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
    logic                timeout_q, timeout_d;
    logic [STAGE_W-1:0]  stall_c;
    logic                stalling_c;

    // State and registered outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= RUN;
            flush_q   <= 1'b0;
            new_pc_q  <= '0;
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            flush_q   <= flush_d;
            new_pc_q  <= new_pc_d;
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

    // Next state, stall decode and watchdog
    always_comb begin
        state_d    = state_q;
        new_pc_d   = new_pc_q;
        stall_c    = STALL_NONE;
        stall_c    = STALL_NONE;
        wdog_d     = '0;
        timeout_d  = 1'b0;

        case (state_q)
            RUN: begin
                if (bus.excp_i) begin
                    // Exception wins over every stall request
                    state_d  = FLUSH;
                    new_pc_d = bus.excp_pc_i;
                end else if (bus.mem_stall_req_i) begin
                    stall_c = STALL_MEM;
                end else if (bus.ex_stall_req_i) begin
                    stall_c = STALL_EX;
                end else if (bus.id_stall_req_i) begin
                    stall_c = STALL_ID;
                end
            end
            FLUSH: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        // Reset also masks the combinational holds
        if (!rst_n_i) begin
            stall_c = STALL_NONE;
        end

        stalling_c = (state_q == RUN) && (stall_c != STALL_NONE);

        if (stalling_c) begin
            // Fire once on the transition into saturation
            wdog_d    = (wdog_q == WDOG_MAX) ? WDOG_MAX : wdog_q + WDOG_W'(1);
            timeout_d = (wdog_q == WDOG_MAX - WDOG_W'(1));
        end

        flush_d = (state_d == FLUSH);
    end

    assign bus.stall_o         = stall_c;
    assign bus.flush_o         = flush_q;
    assign bus.new_pc_o        = new_pc_q;
    assign bus.stall_timeout_o = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturating count of stalled RUN cycles
    always_comb begin
        cnt_d = cnt_q;
        if (stalling_c && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.stall_cnt_o = cnt_q;
`else
    assign bus.stall_cnt_o = '0;
`endif

endmodule
